score_digit_render: RTL and testbench

Downstream consumer of the 16-bit packed BCD score produced by the binary-to-BCD converter. Renders four seven-segment-style decimal digits as a 1-bit pixel mask on the VGA raster. It latches the BCD value once per frame so the displayed digits never tear mid-frame. It delays the sync signals so they stay aligned with its 2-cycle pixel pipeline. Sits between the VGA timing generator and the colour mux.

---
 rtl/score_pkg.sv | 17 +
 rtl/seg7_decode.sv | 32 +++
 rtl/score_digit_render.sv | 159 +++++++++++++++
 tb/tb_score_digit_render.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Package  : score_pkg
// Desc     : Shared constants and types for the score digit renderer.
// Revision : 1.0
// ============================================================================
package score_pkg;

    localparam int DIGIT_COUNT = 4;

    // Segment mask, bit 6 = g ... bit 0 = a
    typedef logic [6:0] seg_mask_t;

    localparam seg_mask_t SEG_DASH = 7'b100_0000;

endpackage : score_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Desc     : Combinational BCD nibble to seven-segment mask; 0xA-0xF give '-'.
// Revision : 1.0
// ============================================================================
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_mask_t  seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0: seg = 7'b011_1111;
            4'd1: seg = 7'b000_0110;
            4'd2: seg = 7'b101_1011;
            4'd3: seg = 7'b100_1111;
            4'd4: seg = 7'b110_0110;
            4'd5: seg = 7'b110_1101;
            4'd6: seg = 7'b111_1101;
            4'd7: seg = 7'b000_0111;
            4'd8: seg = 7'b111_1111;
            4'd9: seg = 7'b110_1111;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/score_digit_render.sv
`default_nettype none
// ============================================================================
// Module   : score_digit_render
// Desc     : Draws a frame-latched 4-digit BCD score as a pixel mask with a
//            2-cycle pipeline and matching sync delay.
//            Define SCORE_LZB_EN to enable leading-zero blanking.
// Revision : 1.0
// ============================================================================
module score_digit_render
    import score_pkg::*;
#(
    parameter int ORIGIN_X  = 16,
    parameter int ORIGIN_Y  = 16,
    parameter int DIGIT_W   = 24,
    parameter int DIGIT_H   = 40,
    parameter int SEG_T     = 4,
    parameter int DIGIT_GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        frame_start,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        pixel_on,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [9:0] c_w        = 10'(DIGIT_W);
    localparam logic [9:0] c_h        = 10'(DIGIT_H);
    localparam logic [9:0] c_t        = 10'(SEG_T);
    localparam logic [9:0] c_origin_y = 10'(ORIGIN_Y);
    localparam logic [9:0] c_half_h   = 10'(DIGIT_H / 2);
    localparam logic [9:0] c_d_lo     = 10'(DIGIT_H - SEG_T);
    localparam logic [9:0] c_g_lo     = 10'(DIGIT_H / 2 - SEG_T / 2);
    localparam logic [9:0] c_g_hi     = 10'(DIGIT_H / 2 + SEG_T / 2);
    localparam logic [9:0] c_bc_lo    = 10'(DIGIT_W - SEG_T);

    logic [15:0]            r_shadow;
    logic [DIGIT_COUNT-1:0] w_blank;
    logic [DIGIT_COUNT-1:0] w_hit_x;
    logic [9:0]             w_lx_k [DIGIT_COUNT];
    logic [9:0]             w_lx;
    logic [9:0]             w_ly;
    logic                   w_in_y;
    logic                   w_in_box;
    logic [3:0]             w_nibble;

    logic       r_in_box;
    logic [3:0] r_nibble;
    logic [9:0] r_lx;
    logic [9:0] r_ly;
    logic       r_video_on;
    logic       r_hsync;
    logic       r_vsync;

    seg_mask_t  w_seg;
    seg_mask_t  w_region;
    logic       w_seg_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 16'h0000;
        end else if (frame_start) begin
            r_shadow <= bcd;
        end
    end

    always_comb begin
        w_blank = '0;
`ifdef SCORE_LZB_EN
        // A digit blanks only if it and every digit to its left are zero
        w_blank[DIGIT_COUNT-1] = (r_shadow[4*(DIGIT_COUNT-1) +: 4] == 4'd0);
        for (int k = DIGIT_COUNT - 2; k > 0; k--) begin
            w_blank[k] = w_blank[k+1] && (r_shadow[4*k +: 4] == 4'd0);
        end
`endif
    end

    generate
        for (genvar k = 0; k < DIGIT_COUNT; k++) begin : g_box
            localparam logic [9:0] c_box_x =
                10'(ORIGIN_X + (DIGIT_COUNT - 1 - k) * (DIGIT_W + DIGIT_GAP));
            // Unsigned wrap makes x left of the box fail the width compare
            assign w_lx_k[k]  = x - c_box_x;
            assign w_hit_x[k] = (w_lx_k[k] < c_w);
        end
    endgenerate

    assign w_ly   = y - c_origin_y;
    assign w_in_y = (w_ly < c_h);

    always_comb begin
        w_in_box = 1'b0;
        w_lx     = '0;
        w_nibble = '0;
        for (int k = 0; k < DIGIT_COUNT; k++) begin
            if (w_hit_x[k]) begin
                w_in_box = w_in_y && !w_blank[k];
                w_lx     = w_lx_k[k];
                w_nibble = r_shadow[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_box   <= 1'b0;
            r_nibble   <= 4'd0;
            r_lx       <= 10'd0;
            r_ly       <= 10'd0;
            r_video_on <= 1'b0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
        end else begin
            r_in_box   <= w_in_box;
            r_nibble   <= w_nibble;
            r_lx       <= w_lx;
            r_ly       <= w_ly;
            r_video_on <= video_on;
            r_hsync    <= hsync_in;
            r_vsync    <= vsync_in;
        end
    end

    seg7_decode u_seg7_decode (
        .nibble (r_nibble),
        .seg    (w_seg)
    );

    assign w_region = {
        (r_ly >= c_g_lo) && (r_ly < c_g_hi),            // g
        (r_lx < c_t)      && (r_ly < c_half_h),         // f
        (r_lx < c_t)      && (r_ly >= c_half_h),        // e
        (r_ly >= c_d_lo),                               // d
        (r_lx >= c_bc_lo) && (r_ly >= c_half_h),        // c
        (r_lx >= c_bc_lo) && (r_ly < c_half_h),         // b
        (r_ly < c_t)                                    // a
    };
    assign w_seg_hit = |(w_region & w_seg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on  <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            pixel_on  <= r_video_on && r_in_box && w_seg_hit;
            hsync_out <= r_hsync;
            vsync_out <= r_vsync;
        end
    end

endmodule : score_digit_render
`default_nettype wire

// File: tb/tb_score_digit_render.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_digit_render
// Desc     : Randomised and directed bench for score_digit_render against a
//            behavioural pixel model. Honours SCORE_LZB_EN.
// Revision : 1.0
// ============================================================================
module tb_score_digit_render;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd;
    logic        frame_start;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        pixel_on;
    logic        hsync_out;
    logic        vsync_out;

    score_digit_render dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd         (bcd),
        .frame_start (frame_start),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pixel_on    (pixel_on),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] shadow_m;
    logic [2:0]  exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Segment sets per digit, written as the conventional letter lists
    function automatic bit seg_lit(input int d, input int lx, input int ly);
        string segs;
        bit    hit;
        hit = 1'b0;
        case (d)
            0: segs = "abcdef";
            1: segs = "bc";
            2: segs = "abdeg";
            3: segs = "abcdg";
            4: segs = "bcfg";
            5: segs = "acdfg";
            6: segs = "acdefg";
            7: segs = "abc";
            8: segs = "abcdefg";
            9: segs = "abcdfg";
            default: segs = "g";
        endcase
        for (int i = 0; i < segs.len(); i++) begin
            case (segs[i])
                "a": hit |= (ly < 4);
                "b": hit |= (lx >= 20) && (ly < 20);
                "c": hit |= (lx >= 20) && (ly >= 20);
                "d": hit |= (ly >= 36);
                "e": hit |= (lx < 4) && (ly >= 20);
                "f": hit |= (lx < 4) && (ly < 20);
                "g": hit |= (ly >= 18) && (ly < 22);
                default: ;
            endcase
        end
        return hit;
    endfunction

    function automatic bit model_pixel(input logic [15:0] s, input int px, input int py, input bit vid);
        bit lit;
        bit lead;
        bit blank;
        int d;
        int bx;
        lit  = 1'b0;
        lead = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            d    = int'(s[4*k +: 4]);
            bx   = 16 + (3 - k) * 32;
            lead = lead && (d == 0);
`ifdef SCORE_LZB_EN
            blank = lead && (k != 0);
`else
            blank = 1'b0;
`endif
            if (vid && !blank && px >= bx && px < bx + 24 && py >= 16 && py < 56)
                lit = seg_lit(d, px - bx, py - 16);
        end
        return lit;
    endfunction

    task automatic step(input int px, input int py, input bit vid, input bit fs, input bit hs, input bit vs);
        logic [2:0] e;
        x           = 10'(px);
        y           = 10'(py);
        video_on    = vid;
        frame_start = fs;
        hsync_in    = hs;
        vsync_in    = vs;
        exp_q.push_back({hs, vs, model_pixel(shadow_m, px, py, vid)});
        if (fs) shadow_m = bcd;
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("pixel_on", 32'(pixel_on), 32'(e[0]));
            check("hsync_out", 32'(hsync_out), 32'(e[2]));
            check("vsync_out", 32'(vsync_out), 32'(e[1]));
        end else begin
            check("pixel_on_after_reset", 32'(pixel_on), 32'd0);
            check("hsync_after_reset", 32'(hsync_out), 32'd1);
            check("vsync_after_reset", 32'(vsync_out), 32'd1);
        end
    endtask

    task automatic latch(input logic [15:0] v);
        bcd = v;
        step(300, 300, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] masks [5];
        masks[0] = 16'h0000; masks[1] = 16'h000F; masks[2] = 16'h00FF;
        masks[3] = 16'h0FFF; masks[4] = 16'hFFFF;

        rst_n = 1'b0; bcd = 16'h0000; frame_start = 1'b0;
        x = '0; y = '0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        shadow_m = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pixel_on", 32'(pixel_on), 32'd0);
        check("reset_hsync", 32'(hsync_out), 32'd1);
        check("reset_vsync", 32'(vsync_out), 32'd1);
        rst_n = 1'b1;

        // Reset shadow shows zeros until first latch
        step(18, 17, 1'b1, 1'b0, 1'b1, 1'b1);
        step(113, 30, 1'b1, 1'b0, 1'b1, 1'b1);

        latch(16'h1234);
        step(38, 20, 1'b1, 1'b0, 1'b1, 1'b1);
        step(18, 18, 1'b1, 1'b0, 1'b1, 1'b1);
        step(90, 36, 1'b1, 1'b0, 1'b1, 1'b1);

        latch(16'h0042);
        step(18, 17, 1'b1, 1'b0, 1'b1, 1'b1);
        step(50, 17, 1'b1, 1'b0, 1'b1, 1'b1);
        latch(16'h0000);
        step(113, 30, 1'b1, 1'b0, 1'b1, 1'b1);
        step(18, 17, 1'b1, 1'b0, 1'b1, 1'b1);
        latch(16'h00A0);
        step(90, 36, 1'b1, 1'b0, 1'b1, 1'b1);
        step(90, 17, 1'b1, 1'b0, 1'b1, 1'b1);
        step(18, 17, 1'b1, 1'b0, 1'b1, 1'b1);

        // Frame latch: bcd change without frame_start must not show
        latch(16'h1234);
        bcd = 16'h5678;
        step(38, 20, 1'b1, 1'b0, 1'b1, 1'b1);
        step(38, 20, 1'b1, 1'b1, 1'b1, 1'b1);
        step(38, 20, 1'b1, 1'b0, 1'b1, 1'b1);
        step(38, 20, 1'b0, 1'b0, 1'b1, 1'b1);

        // Sync delay
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Mid-line reset while a lit pixel and low syncs are in flight
        latch(16'h1234);
        repeat (3) step(38, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_reset_pixel_on", 32'(pixel_on), 32'd0);
        check("async_reset_hsync", 32'(hsync_out), 32'd1);
        check("async_reset_vsync", 32'(vsync_out), 32'd1);
        exp_q.delete();
        shadow_m = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(38, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(18, 17, 1'b1, 1'b0, 1'b0, 1'b0);
        step(38, 20, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            bit fs;
            fs = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
                bcd = 16'($urandom) & masks[$urandom_range(0, 4)];
            step($urandom_range(0, 150), $urandom_range(0, 70),
                 ($urandom_range(0, 7) != 0), fs,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_score_digit_render
`default_nettype wire
